// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage PC generator.
package pc_pkg;

    // Top-level control state: BOOT holds one cycle after reset, RUN is steady state.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    // Which source produced the PC update on a given edge.
    typedef enum logic [2:0] {
        SRC_NONE   = 3'd0,
        SRC_EXC    = 3'd1,
        SRC_ERET   = 3'd2,
        SRC_JUMP   = 3'd3,
        SRC_BRANCH = 3'd4,
        SRC_PEND   = 3'd5,
        SRC_SEQ    = 3'd6
    } pc_src_e;

    localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR_DEF   = 32'h0000_0180;
    localparam int          PC_INC_DEF          = 4;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: picks the winning PC source for this edge
// and tells the register stage what to load into pc and the pending buffer.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = PC_EXC_VECTOR_DEF[WIDTH-1:0]
) (
    input  logic             run,
    input  logic             advance,
    input  logic             exc,
    input  logic             eret,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             pend_valid,
    input  logic [WIDTH-1:0] pend_target,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_seq,
    input  logic [WIDTH-1:0] epc,
    output pc_src_e          src,
    output logic [WIDTH-1:0] next_pc,
    output logic             pc_load,
    output logic             pend_set,
    output logic             pend_clr,
    output logic [WIDTH-1:0] redir_target
);

    // First-match priority: exc, eret, jump/branch, pending apply, sequential.
    always_comb begin
        src          = SRC_NONE;
        next_pc      = pc;
        pc_load      = 1'b0;
        pend_set     = 1'b0;
        pend_clr     = 1'b0;
        redir_target = jump ? jump_target : branch_target;

        if (run) begin
            if (exc) begin
                // Exceptions act even while stalled; any queued redirect is stale.
                src      = SRC_EXC;
                next_pc  = EXC_VECTOR;
                pc_load  = 1'b1;
                pend_clr = 1'b1;
            end else if (eret) begin
                src      = SRC_ERET;
                next_pc  = epc;
                pc_load  = 1'b1;
                pend_clr = 1'b1;
            end else if (jump || branch_taken) begin
                src = jump ? SRC_JUMP : SRC_BRANCH;
                if (advance) begin
                    next_pc  = redir_target;
                    pc_load  = 1'b1;
                    pend_clr = 1'b1;
                end else begin
                    // Cannot move now: park it, overwriting any older pending target.
                    pend_set = 1'b1;
                end
            end else if (advance && pend_valid) begin
                src      = SRC_PEND;
                next_pc  = pend_target;
                pc_load  = 1'b1;
                pend_clr = 1'b1;
            end else if (advance) begin
                src     = SRC_SEQ;
                next_pc = pc_seq;
                pc_load = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: reset/exception vectors, stall and
// fetch-ready gating, prioritised redirects with a one-entry pending buffer,
// and EPC storage for eret.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR_DEF[WIDTH-1:0],
    parameter logic [WIDTH-1:0] EXC_VECTOR   = PC_EXC_VECTOR_DEF[WIDTH-1:0],
    parameter int               INC          = PC_INC_DEF
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus_inc_o,
    output logic             pc_valid_o,
    output logic [WIDTH-1:0] epc_o,
    output logic             misaligned_o
);

    pc_state_e        state;
    pc_state_e        state_nxt;
    logic             run;
    logic             advance;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_target;

    pc_src_e          src;
    logic [WIDTH-1:0] next_pc;
    logic             pc_load;
    logic             pend_set;
    logic             pend_clr;
    logic [WIDTH-1:0] redir_target;

    assign run           = (state == RUN);
    assign advance       = run && fetch_ready && !stall;
    assign pc_plus_inc_o = pc_o + WIDTH'(INC);
    assign misaligned_o  = |pc_o[1:0];

    pc_redirect_arb #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .run           (run),
        .advance       (advance),
        .exc           (exc),
        .eret          (eret),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pend_valid    (pend_valid),
        .pend_target   (pend_target),
        .pc            (pc_o),
        .pc_seq        (pc_plus_inc_o),
        .epc           (epc_o),
        .src           (src),
        .next_pc       (next_pc),
        .pc_load       (pc_load),
        .pend_set      (pend_set),
        .pend_clr      (pend_clr),
        .redir_target  (redir_target)
    );

    // FSM next state and valid flag: BOOT lasts exactly one edge, RUN is sticky.
    always_comb begin
        state_nxt  = state;
        pc_valid_o = 1'b0;
        case (state)
            BOOT: begin
                state_nxt  = RUN;
                pc_valid_o = 1'b0;
            end
            RUN: begin
                state_nxt  = RUN;
                pc_valid_o = 1'b1;
            end
            default: begin
                state_nxt  = BOOT;
                pc_valid_o = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch address register, loaded only when the arbiter selects a source.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pc_o <= RESET_VECTOR;
        end else if (pc_load) begin
            pc_o <= next_pc;
        end
    end

    // EPC captures the interrupted fetch address on an exception.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            epc_o <= '0;
        end else if (src == SRC_EXC) begin
            epc_o <= pc_o;
        end
    end

    // One-entry pending redirect buffer; a set in the same edge beats a clear.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (pend_set) begin
            pend_valid  <= 1'b1;
            pend_target <= redir_target;
        end else if (pend_clr) begin
            pend_valid  <= 1'b0;
        end
    end

endmodule
